// File: rtl/byte_serializer_pkg.sv
// Shared definitions for the byte serializer: FSM state encoding and default word width.
package byte_serializer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Code 2'd3 is unused; the FSM treats it as illegal and returns to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register: LOAD captures D, SHIFT moves toward bit 0 with zero fill.
module piso_shift_reg
  import byte_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             LOAD,
  input  logic             SHIFT,
  input  logic [WIDTH-1:0] D,
  output logic             Q0
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  // LOAD wins over SHIFT.
  always_comb begin
    // NOTE: the hold value is assigned first so every path writes shreg_d and no latch is inferred.
    shreg_d = shreg_q;
    if (LOAD) begin
      shreg_d = D;
    end else if (SHIFT) begin
      shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!RSTn) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign Q0 = shreg_q[0];

endmodule

// File: rtl/byte_serializer.sv
// Captures a parallel word on START and streams it LSB first over a valid/ready bit link.
module byte_serializer
  import byte_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             START,
  output logic             BUSY,
  output logic             SOUT,
  output logic             SVALID,
  input  logic             SREADY,
  output logic             DONE
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             svalid_q, svalid_d;
  logic             done_q, done_d;
  logic             load;
  logic             shift;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    svalid_d = svalid_q;
    done_d   = done_q;
    load     = 1'b0;
    shift    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          load     = 1'b1;
          cnt_d    = '0;
          busy_d   = 1'b1;
          svalid_d = 1'b1;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // The last bit is not shifted out, so SOUT keeps it until the next capture.
        if (SREADY) begin
          if (cnt_q == CNT_LAST) begin
            svalid_d = 1'b0;
            done_d   = 1'b1;
            state_d  = ST_DONE;
          end else begin
            shift = 1'b1;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d    = '0;
        busy_d   = 1'b0;
        svalid_d = 1'b0;
        done_d   = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      svalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      svalid_q <= svalid_d;
      done_q   <= done_d;
    end
  end

  piso_shift_reg #(
    .WIDTH(WIDTH)
  ) u_piso (
    .CLK  (CLK),
    .RSTn (RSTn),
    .LOAD (load),
    .SHIFT(shift),
    .D    (DATA_IN),
    .Q0   (SOUT)
  );

  assign BUSY   = busy_q;
  assign SVALID = svalid_q;
  assign DONE   = done_q;

endmodule

// File: tb/tb_byte_serializer.sv
// Self-checking bench: directed + random 8-bit traffic against a word-level timeline model, plus a 2-bit instance.
module tb_byte_serializer;

  localparam int W = 8;
  localparam int N = 400;

  logic       CLK;
  logic       RSTn;
  logic [7:0] DATA_IN;
  logic       START;
  logic       SREADY;
  logic       BUSY, SOUT, SVALID, DONE;

  logic [1:0] data2;
  logic       start2, rdy2;
  logic       busy2, sout2, svalid2, done2;

  int vectors     = 0;
  int miscompares = 0;

  logic       st_a  [N];
  logic [7:0] dat_a [N];
  logic       rdy_a [N];
  logic       e_busy[N];
  logic       e_valid[N];
  logic       e_done[N];
  logic       e_sout[N];

  byte_serializer #(.WIDTH(8)) dut8 (
    .CLK(CLK), .RSTn(RSTn), .DATA_IN(DATA_IN), .START(START), .BUSY(BUSY),
    .SOUT(SOUT), .SVALID(SVALID), .SREADY(SREADY), .DONE(DONE)
  );

  byte_serializer #(.WIDTH(2)) dut2 (
    .CLK(CLK), .RSTn(RSTn), .DATA_IN(data2), .START(start2), .BUSY(busy2),
    .SOUT(sout2), .SVALID(svalid2), .SREADY(rdy2), .DONE(done2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [7:0] word;
    logic [1:0] w2;
    logic       last_bit;
    int         c;
    int         i;
    bit         finished;

    RSTn = 1'b0; START = 1'b0; SREADY = 1'b0; DATA_IN = '0;
    start2 = 1'b0; rdy2 = 1'b1; data2 = '0;

    // Stimulus table: random background, directed scenarios in the first 64 cycles.
    for (int k = 0; k < N; k++) begin
      st_a[k]  = ($urandom_range(3) == 0);
      dat_a[k] = 8'($urandom);
      rdy_a[k] = ($urandom_range(3) != 0);
    end
    for (int k = 0; k < 64; k++) begin
      st_a[k]  = 1'b0;
      rdy_a[k] = 1'b1;
    end
    st_a[0]  = 1'b1; dat_a[0]  = 8'hA5;
    st_a[12] = 1'b1; dat_a[12] = 8'h3C;
    rdy_a[15] = 1'b0; rdy_a[16] = 1'b0; rdy_a[17] = 1'b0;
    st_a[26] = 1'b1; dat_a[26] = 8'hFF;
    st_a[31] = 1'b1; dat_a[31] = 8'h00;
    for (int k = 38; k < 58; k++) begin
      st_a[k]  = 1'b1;
      dat_a[k] = (k < 48) ? 8'h55 : 8'hAA;
    end

    // Word-level timeline: capture when idle and START, one bit per ready edge,
    // DONE after the last transfer, one forced idle cycle, SOUT then holds the MSB.
    c = 0;
    last_bit = 1'b0;
    while (c < N) begin
      if (st_a[c]) begin
        word = dat_a[c];
        i = 0;
        e_busy[c] = 1'b1; e_valid[c] = 1'b1; e_done[c] = 1'b0; e_sout[c] = word[0];
        c++;
        finished = 1'b0;
        while (c < N && !finished) begin
          if (rdy_a[c] && i == W - 1) begin
            e_busy[c] = 1'b1; e_valid[c] = 1'b0; e_done[c] = 1'b1; e_sout[c] = word[W-1];
            last_bit = word[W-1];
            c++;
            if (c < N) begin
              e_busy[c] = 1'b0; e_valid[c] = 1'b0; e_done[c] = 1'b0; e_sout[c] = last_bit;
            end
            c++;
            finished = 1'b1;
          end else begin
            if (rdy_a[c]) i++;
            e_busy[c] = 1'b1; e_valid[c] = 1'b1; e_done[c] = 1'b0; e_sout[c] = word[i];
            c++;
          end
        end
      end else begin
        e_busy[c] = 1'b0; e_valid[c] = 1'b0; e_done[c] = 1'b0; e_sout[c] = last_bit;
        c++;
      end
    end

    // Reset state of both instances.
    repeat (2) @(posedge CLK);
    #1;
    check("rst_busy",   BUSY,   1'b0);
    check("rst_sout",   SOUT,   1'b0);
    check("rst_svalid", SVALID, 1'b0);
    check("rst_done",   DONE,   1'b0);
    check("rst2_busy",  busy2,  1'b0);
    check("rst2_valid", svalid2, 1'b0);
    RSTn = 1'b1;

    // Directed and random traffic on the 8-bit instance.
    for (int k = 0; k < N; k++) begin
      START = st_a[k]; DATA_IN = dat_a[k]; SREADY = rdy_a[k];
      tick();
      check($sformatf("busy@%0d", k),   BUSY,   e_busy[k]);
      check($sformatf("svalid@%0d", k), SVALID, e_valid[k]);
      check($sformatf("done@%0d", k),   DONE,   e_done[k]);
      check($sformatf("sout@%0d", k),   SOUT,   e_sout[k]);
    end

    // Drain any word in flight, bounded.
    START = 1'b0; SREADY = 1'b1;
    for (int k = 0; k < 20 && BUSY; k++) tick();
    check("drain_idle", BUSY, 1'b0);

    // Mid-word asynchronous reset.
    DATA_IN = 8'h81; START = 1'b1;
    tick();
    START = 1'b0;
    check("mw_bit0", SOUT, 1'b1);
    check("mw_valid", SVALID, 1'b1);
    repeat (3) tick();
    check("mw_bit3", SOUT, 1'b0);
    #2 RSTn = 1'b0;
    #1;
    check("mw_rst_busy",   BUSY,   1'b0);
    check("mw_rst_svalid", SVALID, 1'b0);
    check("mw_rst_sout",   SOUT,   1'b0);
    check("mw_rst_done",   DONE,   1'b0);
    tick();
    check("mw_rst_nodone", DONE, 1'b0);
    check("mw_rst_hold",   BUSY, 1'b0);
    #2 RSTn = 1'b1;
    DATA_IN = 8'h01; START = 1'b1;
    tick();
    START = 1'b0;
    DATA_IN = 8'hFE;
    check("after_rst_b0", SOUT, 1'b1);
    for (int b = 1; b < W; b++) begin
      tick();
      check($sformatf("after_rst_b%0d", b), SOUT, 1'b0);
      check($sformatf("after_rst_v%0d", b), SVALID, 1'b1);
    end
    tick();
    check("after_rst_done", DONE, 1'b1);
    check("after_rst_dval", SVALID, 1'b0);
    tick();
    check("after_rst_idle", BUSY, 1'b0);
    check("after_rst_dclr", DONE, 1'b0);

    // WIDTH=2 instance: 2'b10 first, then random words.
    for (int n = 0; n < 6; n++) begin
      w2 = (n == 0) ? 2'b10 : 2'($urandom);
      data2 = w2; start2 = 1'b1;
      tick();
      start2 = 1'b0;
      check($sformatf("w2_%0d_b0", n), sout2, w2[0]);
      check($sformatf("w2_%0d_v0", n), svalid2, 1'b1);
      check($sformatf("w2_%0d_busy", n), busy2, 1'b1);
      tick();
      check($sformatf("w2_%0d_b1", n), sout2, w2[1]);
      check($sformatf("w2_%0d_v1", n), svalid2, 1'b1);
      tick();
      check($sformatf("w2_%0d_done", n), done2, 1'b1);
      check($sformatf("w2_%0d_vdone", n), svalid2, 1'b0);
      tick();
      check($sformatf("w2_%0d_idle", n), busy2, 1'b0);
      check($sformatf("w2_%0d_dclr", n), done2, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
